trap_ctrl: RTL

Machine-mode trap sequencer for the RV32 core. It detects ECALL, EBREAK, MRET and a synchronised external interrupt at the retire point, and reports trap entry (epc, cause) to the CSR unit. After a fixed drain interval it redirects the fetch PC to the handler address (mtvec) or the return address (mepc) supplied by the CSR unit. It sits between the CSR unit and the PC/fetch logic, and is the consumer of mtvec/mepc.

---
 rtl/trap_ctrl_pkg.sv | 33 +++
 rtl/trap_ctrl_sync_ff.sv | 32 +++
 rtl/trap_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared constants and types for the machine-mode trap sequencer.
// Holds the instruction words it decodes, the mcause codes, FSM encodings and the target kinds.
package trap_ctrl_pkg;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000b;
  localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;
  localparam logic [31:0] CAUSE_IRQ    = 32'h8000_000b;

  localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
  localparam logic [1:0] ST_DRAIN_ENC    = 2'd1;
  localparam logic [1:0] ST_REDIRECT_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_DRAIN    = ST_DRAIN_ENC,
    ST_REDIRECT = ST_REDIRECT_ENC
  } state_t;

  typedef enum logic {
    TGT_TRAP = 1'b0,
    TGT_RET  = 1'b1
  } target_t;

  // Fetch targets are always word aligned; the mode bits of mtvec are dropped.
  function automatic logic [31:0] align4(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/trap_ctrl_sync_ff.sv
// Flop chain synchroniser for a single asynchronous level input.
// Reset clears every stage so the synchronised output starts low.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) chain_reg[gi] <= 1'b0;
          else      chain_reg[gi] <= d;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) chain_reg[gi] <= 1'b0;
          else      chain_reg[gi] <= chain_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: detects ECALL/EBREAK/MRET/interrupt at retire,
// reports trap entry to the CSR unit and redirects fetch after a drain interval.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int DRAIN       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        valid,
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        irq,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        trap_we,
  output logic [31:0] trap_epc,
  output logic [31:0] trap_cause,
  output logic        in_handler,
  output logic [31:0] trap_cnt
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN - 1);

  state_t      state_reg;
  target_t     target_reg;
  logic [3:0]  cnt_reg;
  logic        irq_s;

  logic        is_mret;
  logic        is_ecall;
  logic        is_ebreak;
  logic        take_irq;
  logic        take_trap;
  logic [31:0] cause_next;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk(clk),
    .rst(rst),
    .d  (irq),
    .q  (irq_s)
  );

  // Interrupts are never nested: a pending irq waits for in_handler to drop.
  always_comb begin
    is_mret    = (ir == INST_MRET);
    is_ecall   = (ir == INST_ECALL);
    is_ebreak  = (ir == INST_EBREAK);
    take_irq   = irq_s && !in_handler;
    take_trap  = !is_mret && (is_ecall || is_ebreak || take_irq);
    cause_next = CAUSE_IRQ;
    if (is_ecall)       cause_next = CAUSE_ECALL;
    else if (is_ebreak) cause_next = CAUSE_EBREAK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      target_reg  <= TGT_TRAP;
      cnt_reg     <= 4'd0;
      stall       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= 32'h0;
      trap_we     <= 1'b0;
      trap_epc    <= 32'h0;
      trap_cause  <= 32'h0;
      in_handler  <= 1'b0;
      trap_cnt    <= 32'h0;
    end else if (!halt) begin
      trap_we  <= 1'b0;
      redirect <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (valid && is_mret) begin
            target_reg <= TGT_RET;
            in_handler <= 1'b0;
            cnt_reg    <= 4'd0;
            stall      <= 1'b1;
            state_reg  <= ST_DRAIN;
          end else if (valid && take_trap) begin
            target_reg <= TGT_TRAP;
            trap_we    <= 1'b1;
            trap_epc   <= pc;
            trap_cause <= cause_next;
            in_handler <= 1'b1;
            trap_cnt   <= trap_cnt + 32'd1;
            cnt_reg    <= 4'd0;
            stall      <= 1'b1;
            state_reg  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // mtvec/mepc are sampled on the last drain edge so late CSR writes land.
          if (cnt_reg == DRAIN_LAST) begin
            redirect    <= 1'b1;
            redirect_pc <= align4((target_reg == TGT_TRAP) ? mtvec : mepc);
            state_reg   <= ST_REDIRECT;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        ST_REDIRECT: begin
          stall     <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          stall     <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
